imm_compress: RTL and testbench

- Inverse of the `ext` immediate extender: takes a 32-bit value and searches for a 16-bit `imm` and 2-bit `EOp` such that ext(imm, EOp) reproduces the value exactly.
- Multi-cycle. Tries one EOp candidate per clock in fixed priority order and reports the first match.
- Used by the assembler-side and test-generation datapath to pick the encoding for constants.

---
 rtl/imm_compress_pkg.sv | 8 +
 rtl/imm_compress_if.sv | 12 +
 rtl/imm_compress_ext.sv | 14 +
 rtl/imm_compress.sv | 55 +++++
 tb/tb_imm_compress.sv | 148 ++++++++++++++
 5 files changed

// File: rtl/imm_compress_pkg.sv
// imm_compress_pkg: extension-mode and FSM state encodings shared by the compressor.
package imm_compress_pkg;
  localparam logic [1:0] EXT_SIGN = 2'b00;
  localparam logic [1:0] EXT_ZERO = 2'b01;
  localparam logic [1:0] EXT_LUI  = 2'b10;
  localparam logic [1:0] EXT_SHL2 = 2'b11;
  typedef enum logic [1:0] {IDLE, TRY, DONE} state_t;
endpackage

// File: rtl/imm_compress_if.sv
// imm_compress_if: request/result bundle between a requester and the compressor.
interface imm_compress_if;
  logic        start;
  logic [31:0] val;
  logic        busy;
  logic        done;
  logic        found;
  logic [15:0] imm;
  logic [1:0]  EOp;
  modport master (output start, val, input busy, done, found, imm, EOp);
  modport slave (input start, val, output busy, done, found, imm, EOp);
endinterface

// File: rtl/imm_compress_ext.sv
// imm_compress_ext: forward immediate extender, reused as the match checker.
module imm_compress_ext
  import imm_compress_pkg::*;
(
  input  logic [15:0] imm,
  input  logic [1:0]  eop,
  output logic [31:0] ext
);
  logic [31:0] sx;
  assign sx  = {{16{imm[15]}}, imm};
  assign ext = eop == EXT_SIGN ? sx :
               eop == EXT_ZERO ? {16'h0000, imm} :
               eop == EXT_LUI  ? {imm, 16'h0000} : {sx[29:0], 2'b00};
endmodule

// File: rtl/imm_compress.sv
// imm_compress: searches EOp modes in priority order for an imm that extends back to val.
module imm_compress
  import imm_compress_pkg::*;
(
  input logic         clk,
  input logic         reset,
  imm_compress_if.slave bus
);
  state_t      state;
  logic [1:0]  idx;
  logic [31:0] v;
  logic [15:0] cand;
  logic [31:0] ext;
  logic        match;
  assign cand  = idx == EXT_LUI ? v[31:16] : idx == EXT_SHL2 ? v[17:2] : v[15:0];
  assign match = ext == v;
  // Matching through the forward extender guarantees round-trip consistency.
  imm_compress_ext u_ext (.imm(cand), .eop(idx), .ext(ext));
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= 2'd0;
      v         <= 32'h0;
      bus.busy  <= 1'b0;
      bus.done  <= 1'b0;
      bus.found <= 1'b0;
      bus.imm   <= 16'h0000;
      bus.EOp   <= EXT_SIGN;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          v        <= bus.val;
          idx      <= 2'd0;
          state    <= TRY;
          bus.busy <= 1'b1;
        end
        TRY: if (match || idx == EXT_SHL2) begin
          bus.imm   <= match ? cand : 16'h0000;
          bus.EOp   <= match ? idx : EXT_SIGN;
          bus.found <= match;
          bus.busy  <= 1'b0;
          bus.done  <= 1'b1;
          state     <= DONE;
        end else begin
          idx <= idx + 2'd1;
        end
        DONE: begin
          bus.done <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_imm_compress.sv
// tb_imm_compress: directed and random round-trip checks against a rule-based model.
module tb_imm_compress;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  imm_compress_if bus ();
  imm_compress dut (.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ext_model(input logic [15:0] i, input logic [1:0] e);
    longint s = longint'($signed(i));
    case (e)
      2'd0: return 32'(s);
      2'd1: return 32'(i);
      2'd2: return 32'(i) * 65536;
      default: return 32'(s * 4);
    endcase
  endfunction

  // Rules evaluated on the value as integers, first satisfied mode wins.
  task automatic model(input logic [31:0] v, output logic f, output logic [1:0] e, output logic [15:0] i);
    longint s = longint'($signed(v));
    longint u = longint'(v);
    f = 1'b1;
    if (s >= -32768 && s <= 32767) begin e = 2'd0; i = 16'(u); end
    else if (u < 65536) begin e = 2'd1; i = 16'(u); end
    else if (u % 65536 == 0) begin e = 2'd2; i = 16'(u / 65536); end
    else if (u % 4 == 0 && s / 4 >= -32768 && s / 4 <= 32767) begin e = 2'd3; i = 16'(s / 4); end
    else begin f = 1'b0; e = 2'd0; i = 16'h0000; end
  endtask

  // Accept a start at edge 0 and count edges until done is seen.
  task automatic search(input logic [31:0] value, input bit hold, output int edges, output int busy_cnt);
    bus.start = 1'b1;
    bus.val = value;
    @(posedge clk);
    #1;
    if (!hold) bus.start = 1'b0;
    bus.val = $urandom;
    edges = 0;
    busy_cnt = 0;
    while (!bus.done && edges < 10) begin
      if (bus.busy) busy_cnt++;
      @(posedge clk);
      #1;
      edges++;
      if (hold) bus.val = $urandom;
    end
    bus.start = 1'b0;
    if (!bus.done) check("done_timeout", 32'(edges), 32'd99);
  endtask

  task automatic run(input string tag, input logic [31:0] value, input bit hold);
    int edges, busy_cnt;
    logic f;
    logic [1:0] e;
    logic [15:0] i;
    model(value, f, e, i);
    search(value, hold, edges, busy_cnt);
    check({tag, "_lat"}, 32'(edges), f ? 32'(e) + 1 : 32'd4);
    check({tag, "_busy"}, 32'(busy_cnt), f ? 32'(e) + 1 : 32'd4);
    check({tag, "_found"}, 32'(bus.found), 32'(f));
    check({tag, "_eop"}, 32'(bus.EOp), 32'(e));
    check({tag, "_imm"}, 32'(bus.imm), 32'(i));
    @(posedge clk);
    #1;
    check({tag, "_pulse"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    int edges, busy_cnt;
    int saw_done;
    logic [15:0] ri;
    logic [1:0] re;
    logic [31:0] rv;
    bus.start = 1'b0;
    bus.val = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_found", 32'(bus.found), 32'd0);
    check("rst_imm", 32'(bus.imm), 32'd0);
    check("rst_eop", 32'(bus.EOp), 32'd0);
    reset = 1'b0;
    run("sign", 32'hFFFF8000, 1'b0);
    check("sign_exp_imm", 32'(bus.imm), 32'h8000);
    run("zero", 32'h0000FFFF, 1'b0);
    check("zero_exp_eop", 32'(bus.EOp), 32'd1);
    run("lui_hold", 32'h12340000, 1'b1);
    check("lui_exp_imm", 32'(bus.imm), 32'h1234);
    run("shl2", 32'hFFFE0004, 1'b0);
    check("shl2_exp_imm", 32'(bus.imm), 32'h8001);
    run("lui2", 32'hABCD0000, 1'b0);
    bus.start = 1'b1;
    bus.val = 32'h00012345;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check("abort_busy_pre", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_found", 32'(bus.found), 32'd0);
    check("abort_imm", 32'(bus.imm), 32'd0);
    check("abort_eop", 32'(bus.EOp), 32'd0);
    saw_done = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (bus.done) saw_done++;
    end
    check("abort_no_done", 32'(saw_done), 32'd0);
    bus.start = 1'b1;
    bus.val = 32'h00001234;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.start = 1'b0;
    check("rst_over_start", 32'(bus.busy), 32'd0);
    run("nomatch", 32'h00012345, 1'b0);
    run("zero_val", 32'h00000000, 1'b0);
    for (int n = 0; n < 40; n++) begin
      ri = 16'($urandom);
      re = 2'($urandom);
      rv = ext_model(ri, re);
      run("rand", rv, n[0]);
      check("rand_found1", 32'(bus.found), 32'd1);
      check("rand_roundtrip", ext_model(bus.imm, bus.EOp), rv);
      check("rand_prio", 32'(bus.EOp <= re), 32'd1);
    end
    for (int n = 0; n < 10; n++) run("rand_raw", $urandom, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
